// File: rtl/online_sd_multiplier.sv
// online_sd_multiplier
//   Radix-2 online (MSD-first) signed-digit multiplier. Consumes NDIG
//   borrow-save operand digit pairs and emits NDIG borrow-save product
//   digits, DELTA cycles behind the inputs. The residual is kept exact
//   (no truncation), so the result is within 2^-NDIG of X*Y.
//
//   Parameters: NDIG (2..64, must be >= DELTA), DELTA (2..4).
//
//   Ports:
//     clk            rising-edge clock
//     rst_n          asynchronous active-low reset (assert async, release sync)
//     start          one-cycle pulse, accepted only when idle
//     x_digit        operand X digit, value = x_digit[1] - x_digit[0]
//     y_digit        operand Y digit, same encoding
//     digit_valid    (only with OSDM_INPUT_STALL_EN) digits present this edge
//     read_indicator digits are sampled on the next rising edge
//     product_digit  product digit (+1=2'b10, -1=2'b01, 0=2'b00)
//     output_ready   product_digit valid this cycle
//     busy           operation in progress
//     done           one-cycle pulse after the last product digit
//
//   Optional build macro: OSDM_INPUT_STALL_EN adds the digit_valid input.
//
//   Product digits are Mealy outputs: digit p_k is selected from the residual
//   that includes the digit pair being offered in the same cycle, which is
//   what puts p_1 in the same cycle as operand digit DELTA+1.
//
//   state | meaning
//   IDLE  | waiting for start
//   LOAD  | DELTA cycles, digits accumulated, no product output
//   RUN   | NDIG-DELTA cycles, digits consumed and product digits emitted
//   FLUSH | DELTA cycles, zero digits fed, remaining product digits emitted
//   DONE  | one cycle, done pulse
module online_sd_multiplier #(
  parameter int NDIG  = 16,
  parameter int DELTA = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] x_digit,
  input  logic [1:0] y_digit,
`ifdef OSDM_INPUT_STALL_EN
  input  logic       digit_valid,
`endif
  output logic       read_indicator,
  output logic [1:0] product_digit,
  output logic       output_ready,
  output logic       busy,
  output logic       done
);

  localparam int PW      = NDIG + 2;          // prefix width, NDIG fraction bits
  localparam int FB      = NDIG + DELTA;      // residual fraction bits
  localparam int WW      = NDIG + DELTA + 4;  // residual width
  localparam int CW      = 7;
  localparam int RUN_LEN = NDIG - DELTA;

  localparam logic [CW-1:0] LOAD_TC = CW'(DELTA - 1);
  localparam logic [CW-1:0] RUN_TC  = CW'(RUN_LEN - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic signed [PW-1:0] WT_INIT = {2'b00, 1'b1, {(NDIG-1){1'b0}}};
  localparam logic signed [WW-1:0] HALF    = {4'b0000, 1'b1, {(FB-1){1'b0}}};
  localparam logic signed [WW-1:0] ONE     = {3'b000, 1'b1, {FB{1'b0}}};
  localparam logic signed [WW-1:0] NHALF   = -HALF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [PW-1:0] xp_q, xp_d;
  logic signed [PW-1:0] yp_q, yp_d;
  logic signed [PW-1:0] wt_q, wt_d;
  logic signed [WW-1:0] w_q, w_d;

  // Reset is asserted asynchronously and released through two flops so the
  // state registers never see a release close to a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_core_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_core_n = rst_sync_q[1];

  // ---------------------------------------------------------------------
  // Handshake / stall
  // ---------------------------------------------------------------------
  logic stall;
  logic emit;

  assign read_indicator = (state_q == LOAD) || (state_q == RUN);
  assign busy           = (state_q == LOAD) || (state_q == RUN) || (state_q == FLUSH);
  assign done           = (state_q == DONE);
  assign emit           = (state_q == RUN) || (state_q == FLUSH);

`ifdef OSDM_INPUT_STALL_EN
  assign stall = read_indicator && !digit_valid;
`else
  assign stall = 1'b0;
`endif

  assign output_ready = emit && !stall;

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  // 2'b11 decodes to zero; FLUSH forces zero digits whatever is on the pins.
  logic xpos, xneg, ypos, yneg;

  assign xpos = (state_q != FLUSH) && (x_digit == 2'b10);
  assign xneg = (state_q != FLUSH) && (x_digit == 2'b01);
  assign ypos = (state_q != FLUSH) && (y_digit == 2'b10);
  assign yneg = (state_q != FLUSH) && (y_digit == 2'b01);

  logic signed [PW-1:0] xp_new, yp_new;
  logic signed [PW:0]   tx, ty, t_sum;
  logic signed [WW-1:0] v, w_sel;
  logic                 sel_pos, sel_neg;
  logic [1:0]           p_dig;

  always_comb begin
    xp_new = xp_q;
    if (xpos)      xp_new = xp_q + wt_q;
    else if (xneg) xp_new = xp_q - wt_q;

    yp_new = yp_q;
    if (ypos)      yp_new = yp_q + wt_q;
    else if (yneg) yp_new = yp_q - wt_q;

    // x_j * Y[j-1] + y_j * X[j]
    tx = '0;
    if (xpos)      tx = {yp_q[PW-1], yp_q};
    else if (xneg) tx = -{yp_q[PW-1], yp_q};

    ty = '0;
    if (ypos)      ty = {xp_new[PW-1], xp_new};
    else if (yneg) ty = -{xp_new[PW-1], xp_new};

    t_sum = tx + ty;

    // The 2^-DELTA scaling is free: the term's NDIG-bit fraction lines up
    // with the residual's NDIG+DELTA-bit fraction without shifting.
    v = {w_q[WW-2:0], 1'b0} + {{(WW-PW-1){t_sum[PW]}}, t_sum};

    sel_pos = (v >= HALF);
    sel_neg = (v < NHALF);

    w_sel = v;
    p_dig = 2'b00;
    if (sel_pos) begin
      w_sel = v - ONE;
      p_dig = 2'b10;
    end else if (sel_neg) begin
      w_sel = v + ONE;
      p_dig = 2'b01;
    end
  end

`ifdef OSDM_INPUT_STALL_EN
  // A stalled edge emits no digit; the pin keeps the last emitted digit.
  logic [1:0] last_p_q, last_p_d;

  always_comb begin
    last_p_d = last_p_q;
    if (state_q == IDLE && start) last_p_d = 2'b00;
    else if (output_ready)        last_p_d = p_dig;
  end

  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n) last_p_q <= 2'b00;
    else             last_p_q <= last_p_d;
  end

  assign product_digit = output_ready ? p_dig : last_p_q;
`else
  assign product_digit = output_ready ? p_dig : 2'b00;
`endif

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xp_d    = xp_q;
    yp_d    = yp_q;
    wt_d    = wt_q;
    w_d     = w_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = LOAD_TC;
          xp_d    = '0;
          yp_d    = '0;
          wt_d    = WT_INIT;
          w_d     = '0;
        end
      end

      LOAD: begin
        if (!stall) begin
          xp_d = xp_new;
          yp_d = yp_new;
          wt_d = wt_q >>> 1;
          w_d  = v;
          if (cnt_q == '0) begin
            if (RUN_LEN > 0) begin
              state_d = RUN;
              cnt_d   = RUN_TC;
            end else begin
              state_d = FLUSH;
              cnt_d   = LOAD_TC;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end

      RUN: begin
        if (!stall) begin
          xp_d = xp_new;
          yp_d = yp_new;
          wt_d = wt_q >>> 1;
          w_d  = w_sel;
          if (cnt_q == '0) begin
            state_d = FLUSH;
            cnt_d   = LOAD_TC;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end

      FLUSH: begin
        // Digits are zero here, so the prefixes cannot change.
        w_d = w_sel;
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - CNT_ONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      xp_q    <= '0;
      yp_q    <= '0;
      wt_q    <= '0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xp_q    <= xp_d;
      yp_q    <= yp_d;
      wt_q    <= wt_d;
      w_q     <= w_d;
    end
  end

endmodule

// File: tb/tb_online_sd_multiplier.sv
// Directed bench for online_sd_multiplier at NDIG=8, DELTA=3.
// Cycle numbering: the start pulse is driven in cycle 0 and sampled at edge 0;
// cycle c is the interval that ends at edge c. Inputs change 1 time unit after
// a rising edge, outputs are sampled on the falling edge.
module tb_online_sd_multiplier;

  localparam int NDIG  = 8;
  localparam int DELTA = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] x_digit = 2'b00;
  logic [1:0] y_digit = 2'b00;
  logic       read_indicator;
  logic [1:0] product_digit;
  logic       output_ready;
  logic       busy;
  logic       done;

  online_sd_multiplier #(.NDIG(NDIG), .DELTA(DELTA)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .x_digit        (x_digit),
    .y_digit        (y_digit),
`ifdef OSDM_INPUT_STALL_EN
    .digit_valid    (1'b1),
`endif
    .read_indicator (read_indicator),
    .product_digit  (product_digit),
    .output_ready   (output_ready),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Per-operation observations filled in by run_op.
  int val;        // sum p_k * 2^(NDIG-k)
  int n_out;
  int first_or;
  int done_cyc;
  int done_cnt;
  int bad_digit;
  int ri_err;
  int busy_err;

  function automatic int dv(input logic [1:0] d);
    if (d == 2'b10) return 1;
    if (d == 2'b01) return -1;
    return 0;
  endfunction

  // Caller must be positioned 1 time unit after a rising edge (cycle 0).
  // Digits for cycles past NDIG are driven as 2'b10 to prove FLUSH ignores them.
  task automatic run_op(input logic [15:0] xv, input logic [15:0] yv,
                        input int ncyc, input int extra_start);
    val = 0; n_out = 0; first_or = -1; done_cyc = -1; done_cnt = 0;
    bad_digit = 0; ri_err = 0; busy_err = 0;
    start   = 1'b1;
    x_digit = 2'b00;
    y_digit = 2'b00;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      if (c <= NDIG) begin
        x_digit = xv[2*(NDIG-c)+1 -: 2];
        y_digit = yv[2*(NDIG-c)+1 -: 2];
      end else begin
        x_digit = 2'b10;
        y_digit = 2'b10;
      end
      start = (c == extra_start);
      @(negedge clk);
      if (product_digit == 2'b11) bad_digit++;
      if (read_indicator !== (c <= NDIG)) ri_err++;
      if (busy !== (c <= NDIG + DELTA)) busy_err++;
      if (output_ready === 1'b1) begin
        int k;
        k = c - DELTA;
        n_out++;
        if (first_or < 0) first_or = c;
        if (k >= 1 && k <= NDIG) val += dv(product_digit) * (1 << (NDIG - k));
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = c;
      end
      @(posedge clk); #1;
    end
    start   = 1'b0;
    x_digit = 2'b00;
    y_digit = 2'b00;
  endtask

  task automatic test_reset();
    tests++;
    if ({read_indicator, product_digit, output_ready, busy, done} !== 6'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {read_indicator, product_digit, output_ready, busy, done});
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    tests++;
    if ({read_indicator, product_digit, output_ready, busy, done} !== 6'b0) begin
      fails++;
      $display("FAIL idle_after_release: got %b expected 000000",
               {read_indicator, product_digit, output_ready, busy, done});
    end
  endtask

  task automatic test_half_square();
    run_op(16'h8000, 16'h8000, 14, 0);
    tests++;
    if (val !== 64) begin fails++; $display("FAIL half_sq_value: got %0d expected 64", val); end
    tests++;
    if (first_or !== DELTA + 1) begin fails++; $display("FAIL half_sq_first_ready: got %0d expected %0d", first_or, DELTA + 1); end
    tests++;
    if (done_cyc !== NDIG + DELTA + 1) begin fails++; $display("FAIL half_sq_done_cycle: got %0d expected %0d", done_cyc, NDIG + DELTA + 1); end
    tests++;
    if (n_out !== NDIG) begin fails++; $display("FAIL half_sq_digit_count: got %0d expected %0d", n_out, NDIG); end
    tests++;
    if (done_cnt !== 1) begin fails++; $display("FAIL half_sq_done_count: got %0d expected 1", done_cnt); end
    tests++;
    if (ri_err !== 0) begin fails++; $display("FAIL half_sq_read_indicator: got %0d wrong cycles expected 0", ri_err); end
    tests++;
    if (busy_err !== 0) begin fails++; $display("FAIL half_sq_busy: got %0d wrong cycles expected 0", busy_err); end
  endtask

  task automatic test_neg_mixed();
    // X = -0.5, Y = 0.75 -> -0.375 = -96/256
    run_op(16'h4000, 16'hA000, 14, 0);
    tests++;
    if (val !== -96) begin fails++; $display("FAIL neg_mixed_value: got %0d expected -96", val); end
    tests++;
    if (bad_digit !== 0) begin fails++; $display("FAIL neg_mixed_digit11: got %0d expected 0", bad_digit); end
    tests++;
    if (n_out !== NDIG) begin fails++; $display("FAIL neg_mixed_digit_count: got %0d expected %0d", n_out, NDIG); end
  endtask

  task automatic test_extremes();
    int diff;
    // X = Y = +/-255/256, X*Y = 65025/65536; need |val*256 - 65025| <= 256.
    run_op(16'hAAAA, 16'hAAAA, 14, 0);
    diff = val * 256 - 65025;
    tests++;
    if (diff > 256 || diff < -256) begin fails++; $display("FAIL max_pos_accuracy: got %0d/256 expected 65025/65536 +-1/256", val); end
    tests++;
    if (bad_digit !== 0 || n_out !== NDIG) begin fails++; $display("FAIL max_pos_digits: got bad=%0d count=%0d expected bad=0 count=%0d", bad_digit, n_out, NDIG); end
    run_op(16'h5555, 16'h5555, 14, 0);
    diff = val * 256 - 65025;
    tests++;
    if (diff > 256 || diff < -256) begin fails++; $display("FAIL max_neg_accuracy: got %0d/256 expected 65025/65536 +-1/256", val); end
    tests++;
    if (bad_digit !== 0 || n_out !== NDIG) begin fails++; $display("FAIL max_neg_digits: got bad=%0d count=%0d expected bad=0 count=%0d", bad_digit, n_out, NDIG); end
  endtask

  task automatic test_digit11();
    // X = 10,11,11,00,11,00,11,11 is still 0.5
    run_op(16'hBCCF, 16'h8000, 14, 0);
    tests++;
    if (val !== 64) begin fails++; $display("FAIL digit11_value: got %0d expected 64", val); end
  endtask

  task automatic test_start_ignored();
    run_op(16'h8000, 16'h8000, 14, 5);
    tests++;
    if (done_cnt !== 1 || busy_err !== 0) begin fails++; $display("FAIL start_while_busy: got done=%0d busy_err=%0d expected done=1 busy_err=0", done_cnt, busy_err); end
    tests++;
    if (val !== 64) begin fails++; $display("FAIL start_while_busy_value: got %0d expected 64", val); end
    run_op(16'h8000, 16'h8000, 14, NDIG + DELTA + 1);
    tests++;
    if (done_cnt !== 1 || busy_err !== 0) begin fails++; $display("FAIL start_with_done: got done=%0d busy_err=%0d expected done=1 busy_err=0", done_cnt, busy_err); end
  endtask

  task automatic test_async_reset();
    int seen;
    start   = 1'b1;
    x_digit = 2'b00;
    y_digit = 2'b00;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < 6; c++) begin
      x_digit = (c == 1) ? 2'b10 : 2'b00;
      y_digit = (c == 1) ? 2'b10 : 2'b00;
      @(posedge clk); #1;
    end
    x_digit = 2'b00;
    y_digit = 2'b00;
    #2;
    tests++;
    if (output_ready !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL pre_reset_running: got ready=%b busy=%b expected 1 1", output_ready, busy); end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({read_indicator, product_digit, output_ready, busy, done} !== 6'b0) begin
      fails++;
      $display("FAIL async_reset_outputs: got %b expected 000000",
               {read_indicator, product_digit, output_ready, busy, done});
    end
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || output_ready !== 1'b0) seen++;
    end
    tests++;
    if (seen !== 0) begin fails++; $display("FAIL reset_hold_quiet: got %0d active cycles expected 0", seen); end
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    run_op(16'h8000, 16'h8000, 14, 0);
    tests++;
    if (val !== 64 || done_cyc !== NDIG + DELTA + 1) begin fails++; $display("FAIL after_reset_op: got val=%0d done_cycle=%0d expected 64 %0d", val, done_cyc, NDIG + DELTA + 1); end
  endtask

  task automatic test_back_to_back();
    int first_val;
    // Stop right after the DONE cycle so the next start lands in the IDLE cycle.
    run_op(16'h8000, 16'h8000, NDIG + DELTA + 1, 0);
    first_val = val;
    tests++;
    if (first_val !== 64 || done_cnt !== 1) begin fails++; $display("FAIL b2b_first: got val=%0d done=%0d expected 64 1", first_val, done_cnt); end
    run_op(16'h4000, 16'hA000, 14, 0);
    tests++;
    if (val !== -96) begin fails++; $display("FAIL b2b_second_value: got %0d expected -96", val); end
    tests++;
    if (first_or !== DELTA + 1 || done_cyc !== NDIG + DELTA + 1) begin fails++; $display("FAIL b2b_second_timing: got ready=%0d done=%0d expected %0d %0d", first_or, done_cyc, DELTA + 1, NDIG + DELTA + 1); end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_half_square();
    test_neg_mixed();
    test_extremes();
    test_digit11();
    test_start_ignored();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
